// File: rtl/alu_seq_if.sv
// alu_seq_if -- request/result bundle for the sequential ALU.
//   start/op/A/B : request from master, sampled by the ALU only in IDLE
//   busy/done/C/dbz : status and result returned by the ALU
// The clock and reset are not part of the bundle. They stay plain ports on alu_seq.
interface alu_seq_if #(parameter int WIDTH = 32);
  logic                 start;
  logic [3:0]           op;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   C;
  logic                 dbz;

  modport master (output start, op, A, B, input busy, done, C, dbz);
  modport slave  (input start, op, A, B, output busy, done, C, dbz);
endinterface

// File: rtl/alu_seq.sv
// alu_seq -- sequential ALU with an IDLE/RUN/DONE FSM.
//   clk  : rising-edge clock
//   clr  : asynchronous active-low reset; release is taken on a clk edge
//   bus  : alu_seq_if.slave
//          start/op/A/B are inputs. busy, done (a one-cycle pulse), C (2*WIDTH) and dbz are outputs.
// Single-cycle ops are computed from the bus at the start edge and go straight to DONE.
// MUL (radix-2 Booth) and DIV (signed restoring) take WIDTH RUN cycles.
// Both use the same shift/accumulate pair acc_q/lo_q.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      clr,
  alu_seq_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'd0,  OP_OR  = 4'd1,  OP_ADD = 4'd2,  OP_SUB = 4'd3,
                         OP_MUL = 4'd4,  OP_DIV = 4'd5,  OP_SHR = 4'd6,  OP_SHL = 4'd7,
                         OP_ROR = 4'd8,  OP_ROL = 4'd9,  OP_NEG = 4'd10, OP_NOT = 4'd11,
                         OP_SRA = 4'd12, OP_XOR = 4'd13;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [WIDTH:0]       acc_q, acc_d;     // Booth partial product / division remainder
  logic [WIDTH-1:0]     lo_q, lo_d;       // multiplier bits / dividend->quotient bits
  logic                 qb_q, qb_d;       // Booth q(-1)
  logic [SW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   c_q, c_d;
  logic                 dbz_q, dbz_d;

  function automatic logic [2*WIDTH-1:0] zext(input logic [WIDTH-1:0] x);
    return {{WIDTH{1'b0}}, x};
  endfunction

  function automatic logic [2*WIDTH-1:0] sext(input logic [WIDTH-1:0] x);
    return {{WIDTH{x[WIDTH-1]}}, x};
  endfunction

  // Single-cycle result, taken directly from the bus at the start edge.
  logic [SW-1:0]        sh, shn;
  logic [WIDTH-1:0]     ror_r, rol_r, sra_r;
  logic [2*WIDTH-1:0]   sc_res;

  always_comb begin
    sh     = bus.B[SW-1:0];
    shn    = SW'(0) - sh;              // rotate left by s == rotate right by (WIDTH - s) mod WIDTH
    ror_r  = WIDTH'({bus.A, bus.A} >> sh);
    rol_r  = WIDTH'({bus.A, bus.A} >> shn);
    sra_r  = $signed(bus.A) >>> sh;
    sc_res = '0;                       // reserved opcodes return zero
    case (bus.op)
      OP_AND: sc_res = zext(bus.A & bus.B);
      OP_OR:  sc_res = zext(bus.A | bus.B);
      OP_XOR: sc_res = zext(bus.A ^ bus.B);
      OP_NOT: sc_res = zext(~bus.B);
      OP_SHR: sc_res = zext(bus.A >> sh);
      OP_SHL: sc_res = zext(bus.A << sh);
      OP_ROR: sc_res = zext(ror_r);
      OP_ROL: sc_res = zext(rol_r);
      OP_ADD: sc_res = sext(bus.A + bus.B);
      OP_SUB: sc_res = sext(bus.A - bus.B);
      OP_NEG: sc_res = sext(-bus.B);
      OP_SRA: sc_res = sext(sra_r);
      default: sc_res = '0;
    endcase
  end

  // One Booth step: add/sub the multiplicand, then arithmetic shift {acc, lo, qb} right by one.
  logic [WIDTH:0]       m_ext, b_acc, bn_acc;
  logic [WIDTH-1:0]     bn_lo;
  logic                 bn_qb;

  always_comb begin
    m_ext = {a_q[WIDTH-1], a_q};
    case ({lo_q[0], qb_q})
      2'b01:   b_acc = acc_q + m_ext;
      2'b10:   b_acc = acc_q - m_ext;
      default: b_acc = acc_q;
    endcase
    {bn_acc, bn_lo, bn_qb} = {b_acc[WIDTH], b_acc, lo_q};
  end

  // One restoring-division step on magnitudes. The remainder never exceeds the divisor magnitude.
  // For that reason WIDTH+1 bits are enough to read the borrow.
  logic [WIDTH-1:0]     dvs, d_lo, quot, rem;
  logic [WIDTH:0]       d_trial, d_diff, d_acc;

  always_comb begin
    dvs     = b_q[WIDTH-1] ? -b_q : b_q;
    d_trial = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    d_diff  = d_trial - {1'b0, dvs};
    if (!d_diff[WIDTH]) begin
      d_acc = d_diff;
      d_lo  = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      d_acc = d_trial;
      d_lo  = {lo_q[WIDTH-2:0], 1'b0};
    end
    // The most-negative / -1 case wraps naturally to the most-negative quotient.
    quot = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -d_lo : d_lo;
    rem  = a_q[WIDTH-1] ? -d_acc[WIDTH-1:0] : d_acc[WIDTH-1:0];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    qb_d    = qb_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (bus.start) begin
        op_d  = bus.op;
        a_d   = bus.A;
        b_d   = bus.B;
        acc_d = '0;
        qb_d  = 1'b0;
        cnt_d = '0;
        if (bus.op == OP_MUL) begin
          lo_d    = bus.B;
          state_d = RUN;
        end else if (bus.op == OP_DIV) begin
          lo_d    = bus.A[WIDTH-1] ? -bus.A : bus.A;
          state_d = RUN;
        end else begin
          c_d     = sc_res;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          acc_d = bn_acc;
          lo_d  = bn_lo;
          qb_d  = bn_qb;
        end else begin
          acc_d = d_acc;
          lo_d  = d_lo;
        end
        if (cnt_q == SW'(WIDTH - 1)) begin
          state_d = DONE;
          dbz_d   = 1'b0;
          if (op_q == OP_MUL) begin
            c_d = {bn_acc[WIDTH-1:0], bn_lo};
          end else if (b_q == '0) begin
            c_d   = {a_q, {WIDTH{1'b1}}};
            dbz_d = 1'b1;
          end else begin
            c_d = {rem, quot};
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      qb_q    <= 1'b0;
      cnt_q   <= '0;
      c_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      qb_q    <= qb_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.C    = c_q;
  assign bus.dbz  = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- self-checking bench for alu_seq at WIDTH=32.
// The bench runs directed vectors first, then the busy/reset scenario, then random ops.
// Each result is compared against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain signed arithmetic on ints/longints.
  task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] c, output logic z, output int lat);
    int          sa, sb, s;
    logic [31:0] r;
    sa = a; sb = b; s = int'(b[4:0]);
    z = 1'b0; lat = 1; c = '0;
    case (o)
      4'd0:  c = {32'd0, a & b};
      4'd1:  c = {32'd0, a | b};
      4'd2:  begin r = 32'(sa + sb); c = {{32{r[31]}}, r}; end
      4'd3:  begin r = 32'(sa - sb); c = {{32{r[31]}}, r}; end
      4'd4:  begin c = 64'(longint'(sa) * longint'(sb)); lat = W + 1; end
      4'd5:  begin
        lat = W + 1;
        if (b == 0) begin c = {a, 32'hFFFF_FFFF}; z = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) c = {32'd0, 32'h8000_0000};
        else c = {32'(sa % sb), 32'(sa / sb)};
      end
      4'd6:  c = {32'd0, a >> s};
      4'd7:  c = {32'd0, a << s};
      4'd8:  c = {32'd0, (s == 0) ? a : ((a >> s) | (a << (32 - s)))};
      4'd9:  c = {32'd0, (s == 0) ? a : ((a << s) | (a >> (32 - s)))};
      4'd10: begin r = 32'(-sb); c = {{32{r[31]}}, r}; end
      4'd11: c = {32'd0, ~b};
      4'd12: begin r = 32'(sa >>> s); c = {{32{r[31]}}, r}; end
      4'd13: c = {32'd0, a ^ b};
      default: c = '0;
    endcase
  endtask

  // Issue one op. While busy, the bench scrambles op/A/B and pulses start at random.
  // These inputs must all be ignored.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] ec;
    logic        ez;
    int          elat, cyc;
    model(o, a, b, ec, ez, elat);
    @(negedge clk);
    bus.op = o; bus.A = a; bus.B = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op = 4'($urandom); bus.A = $urandom; bus.B = $urandom;
    cyc = 1;
    while (!bus.done && cyc < 100) begin
      chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
      bus.start = 1'($urandom);
      bus.op = 4'($urandom); bus.A = $urandom; bus.B = $urandom;
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    chk({tag, "_lat"}, 64'(cyc), 64'(elat));
    chk({tag, "_C"}, bus.C, ec);
    chk({tag, "_dbz"}, 64'(bus.dbz), 64'(ez));
    chk({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'({bus.done, bus.busy}), 64'd0);
    chk({tag, "_hold"}, bus.C, ec);
  endtask

  initial begin
    logic [3:0]  o;
    logic [31:0] a, b;
    bus.start = 1'b0; bus.op = '0; bus.A = '0; bus.B = '0;
    #12;
    chk("reset_flags", 64'({bus.busy, bus.done, bus.dbz}), 64'd0);
    chk("reset_C", bus.C, 64'd0);
    @(posedge clk); #2 clr = 1'b1;   // start is driven on the first edge after release

    do_op(4'd2, 32'h7FFF_FFFF, 32'd1,          "add_ovf");
    do_op(4'd4, 32'hFFFF_FFFD, 32'd7,          "mul_m3x7");
    do_op(4'd5, 32'hFFFF_FFF9, 32'd2,          "div_m7d2");
    do_op(4'd5, 32'h8000_0000, 32'hFFFF_FFFF,  "div_ovf");
    do_op(4'd5, 32'd5,         32'd0,          "div_zero");
    do_op(4'd8, 32'd1,         32'd1,          "ror1");
    do_op(4'd9, 32'h8000_0000, 32'd32,         "rol0");
    do_op(4'd4, 32'h8000_0000, 32'h8000_0000,  "mul_minmin");
    do_op(4'd12, 32'h8000_0010, 32'd4,         "sra4");
    do_op(4'd14, 32'hFFFF_FFFF, 32'd3,         "reserved");

    // Abort a MUL at RUN cycle 10.
    // Reset must clear everything at once.
    // Reset must also suppress the done pulse.
    @(negedge clk);
    bus.op = 4'd4; bus.A = 32'd12345; bus.B = 32'd678; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 clr = 1'b0;
    #1;
    chk("abort_flags", 64'({bus.busy, bus.done, bus.dbz}), 64'd0);
    chk("abort_C", bus.C, 64'd0);
    repeat (40) begin
      @(posedge clk); #1;
      chk("abort_no_done", 64'(bus.done), 64'd0);
    end
    @(posedge clk); #2 clr = 1'b1;
    do_op(4'd2, 32'd40, 32'd2, "add_after_rst");

    // Random ops with operands biased toward boundaries.
    for (int i = 0; i < 80; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(0, 40));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_op(o, a, b, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; SHALL be a power of two, 8..64.
REQ-002 Port: clk  in  1  rising-edge clock; the block SHALL use one clock.
REQ-003 Port: clr  in  1  reset; it SHALL be asynchronous and active-low.
REQ-004 Port: start  in  1  operation request, sampled only in IDLE.
REQ-005 Port: op  in  4  opcode: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 SHR, 7 SHL, 8 ROR, 9 ROL, 10 NEG, 11 NOT, 12 SRA, 13 XOR; 14-15 reserved.
REQ-006 Port: A  in  WIDTH  operand A, two's complement.
REQ-007 Port: B  in  WIDTH  operand B, two's complement; for shifts and rotates, B[log2(WIDTH)-1:0] is the amount.
REQ-008 Port: busy  out  1  high in every state except IDLE.
REQ-009 Port: done  out  1  one-cycle pulse; C is valid in that cycle.
REQ-010 Port: C  out  2*WIDTH  result register.
REQ-011 Port: dbz  out  1  divide-by-zero flag, valid with done.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE; IDLE is the reset state.
REQ-013 Capture: start=1 in IDLE SHALL latch op, A and B on that edge.
REQ-014 Single-cycle ops (all except MUL/DIV): IDLE->DONE; done=1 in the cycle after the start edge.
REQ-015 MUL/DIV: IDLE->RUN; RUN lasts exactly WIDTH cycles; then DONE; done=1 WIDTH+1 cycles after the start edge.
REQ-016 DONE->IDLE unconditionally after one cycle.
REQ-017 start SHALL be ignored in RUN and DONE; no queuing.
REQ-018 Operands latched at start SHALL be used; changes on A/B/op while busy SHALL have no effect.
REQ-019 C SHALL update only on entry to DONE and hold until the next DONE.
REQ-020 AND, OR, XOR, NOT(~B), SHR, SHL: result SHALL be zero-extended into C.
REQ-021 ADD, SUB, NEG(-B): result truncated to WIDTH, then sign-extended to 2*WIDTH.
REQ-022 SRA: arithmetic right shift of A; result sign-extended to 2*WIDTH.
REQ-023 ROR/ROL: rotate A by amount; amount 0 SHALL return A; result zero-extended.
REQ-024 MUL: signed WIDTH x WIDTH -> full 2*WIDTH product in C; radix-2 Booth, one step per RUN cycle.
REQ-025 DIV: signed restoring divide, one quotient bit per RUN cycle.
REQ-026 DIV output: C[WIDTH-1:0] = quotient, truncated toward zero; C[2W-1:W] = remainder, with the sign of the dividend.
REQ-027 DIV overflow (A = most negative, B = -1): quotient = most negative value, remainder 0.
REQ-028 DIV with B=0: the block SHALL still run WIDTH cycles; C = {A, all ones}; dbz=1 with done.
REQ-029 dbz SHALL be 0 for every other op or operand.
REQ-030 Reserved opcodes: single-cycle; C=0.
REQ-031 Implementation SHALL be a single datapath: shared shift/accumulate registers for MUL and DIV.

Reset
REQ-032 clr=0 SHALL force, asynchronously: state=IDLE, busy=0, done=0, dbz=0, C=0, internal operand and accumulator registers 0.
REQ-033 Reset mid-RUN SHALL abort the op; no done pulse; the first start after release SHALL behave as from cold reset.
REQ-034 Release of clr SHALL be synchronous to clk; a start on the first edge after release SHALL be accepted.

Verification (WIDTH=32)
REQ-035 ADD: A=0x7FFFFFFF, B=1, start -> next cycle done=1, C=0xFFFFFFFF_80000000.
REQ-036 MUL: A=-3, B=7 -> done 33 cycles after start, C=0xFFFFFFFF_FFFFFFEB; busy high for cycles 1..33.
REQ-037 DIV: A=-7, B=2 -> C={0xFFFFFFFF, 0xFFFFFFFD} (rem -1, quot -3), dbz=0. A=0x80000000, B=-1 -> C={0, 0x80000000}.
REQ-038 DIV by zero: A=5, B=0 -> done after 33 cycles, C={0x00000005, 0xFFFFFFFF}, dbz=1.
REQ-039 ROR: A=0x00000001, B=1 -> C=0x00000000_80000000. ROL: A=0x80000000, B=32 (amount 0) -> C=0x00000000_80000000.
REQ-040 Busy/reset: start MUL; while busy, pulse start with op=ADD -> ignored, MUL result unchanged. Restart MUL, assert clr=0 at RUN cycle 10 -> busy=0, C=0 immediately, no done; the next ADD completes in 1 cycle.
